// File: rtl/sw_pio_capture_pkg.sv
// Shared field layout, FSM encoding and helpers for the switch/key status word.
// Layout of pp_in_axi is fixed here so RTL and software agree on one copy.
package sw_pio_pkg;

    localparam int NBITS    = 14;
    localparam int SW_LSB   = 0;
    localparam int SW_W     = 10;
    localparam int KEY_LSB  = 10;
    localparam int KEY_W    = 4;
    localparam int PEND_BIT = 14;
    localparam int OVF_BIT  = 15;
    localparam int CNT_LSB  = 16;
    localparam int IDX_LSB  = 24;
    localparam int IDX_W    = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        OVF  = 2'd2
    } state_e;

    function automatic logic [IDX_W-1:0] lowest_set_idx(input logic [NBITS-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = NBITS - 1; i >= 0; i--) begin
            if (v[i]) r = IDX_W'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/sw_pio_capture_if.sv
// Pin and PIO bundle between the board, the capture block and soc_system.
// The master side drives raw pins and the HPS output word.
interface sw_pio_capture_if;

    logic [9:0]  sw;
    logic [3:0]  key;
    logic [31:0] pp_out_axi;
    logic [31:0] pp_in_axi;

    modport master (
        output sw,
        output key,
        output pp_out_axi,
        input  pp_in_axi
    );

    modport slave (
        input  sw,
        input  key,
        input  pp_out_axi,
        output pp_in_axi
    );

endinterface

// File: rtl/sw_pio_capture_debounce_bit.sv
// One input bit: 2-FF synchroniser, stability counter and debounced register.
// INV flips the synchronised level so active-low keys report pressed as 1.
module debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter bit INV             = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic db,
    output logic db_nxt
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q, sync_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             db_q, db_d;
    logic             lvl;

    always_comb begin
        sync_d = {sync_q[0], din};
        lvl    = sync_q[1] ^ INV;
        cnt_d  = cnt_q;
        db_d   = db_q;
        if (lvl == db_q) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
            db_d  = lvl;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Sync flops reset to the idle pin level so reset never looks like a change.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= {2{INV}};
            cnt_q  <= '0;
            db_q   <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            db_q   <= db_d;
        end
    end

    assign db     = db_q;
    assign db_nxt = db_d;

endmodule

// File: rtl/sw_pio_capture.sv
// Debounced switch/key status word for the HPS with event count and toggle ack.
// Define SW_PIO_CAPTURE_MASK_EN to take a per-bit event mask from pp_out_axi[27:14].
module sw_pio_capture
    import sw_pio_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int EVT_CNT_W       = 8
) (
    input logic               clk,
    input logic               reset,
    sw_pio_capture_if.slave   bus
);

    logic [NBITS-1:0]     raw;
    logic [NBITS-1:0]     db;
    logic [NBITS-1:0]     db_nxt;
    logic [NBITS-1:0]     en_mask;
    logic [NBITS-1:0]     mchg;
    logic                 evt;
    logic                 ack;
    logic                 unused_pp;

    state_e               state_q, state_d;
    logic [EVT_CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 ack_q, ack_d;
    logic [31:0]          pp_q, pp_d;

    assign raw = {bus.key, bus.sw};

    for (genvar i = 0; i < NBITS; i++) begin : g_db
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .INV            (i >= KEY_LSB)
        ) u_db (
            .clk   (clk),
            .reset (reset),
            .din   (raw[i]),
            .db    (db[i]),
            .db_nxt(db_nxt[i])
        );
    end

`ifdef SW_PIO_CAPTURE_MASK_EN
    logic [NBITS-1:0] en_mask_q;

    always_ff @(posedge clk) begin
        if (reset) en_mask_q <= '0;
        else       en_mask_q <= bus.pp_out_axi[27:14];
    end

    assign en_mask   = en_mask_q;
    assign unused_pp = ^{bus.pp_out_axi[31:28], bus.pp_out_axi[13:1]};
`else
    assign en_mask   = {NBITS{1'b1}};
    assign unused_pp = ^bus.pp_out_axi[31:1];
`endif

    always_comb begin
        mchg  = (db_nxt ^ db) & en_mask;
        evt   = |mchg;
        ack_d = bus.pp_out_axi[0];
        ack   = ack_d ^ ack_q;
        cnt_d = evt ? cnt_q + 1'b1 : cnt_q;
        idx_d = evt ? lowest_set_idx(mchg) : idx_q;
    end

    // An ack in the same cycle as an event retires the old one only.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (evt) state_d = PEND;
            PEND: begin
                if (ack)      state_d = evt ? PEND : IDLE;
                else if (evt) state_d = OVF;
            end
            OVF:  if (ack)    state_d = evt ? PEND : IDLE;
            default:          state_d = IDLE;
        endcase
    end

    always_comb begin
        pp_d                      = '0;
        pp_d[SW_LSB +: SW_W]      = db[SW_W-1:0];
        pp_d[KEY_LSB +: KEY_W]    = db[NBITS-1:SW_W];
        pp_d[PEND_BIT]            = (state_q != IDLE);
        pp_d[OVF_BIT]             = (state_q == OVF);
        pp_d[CNT_LSB +: EVT_CNT_W] = cnt_q;
        pp_d[IDX_LSB +: IDX_W]    = idx_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            ack_q   <= 1'b0;
            pp_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            ack_q   <= ack_d;
            pp_q    <= pp_d;
        end
    end

    assign bus.pp_in_axi = pp_q;

endmodule

// File: tb/tb_sw_pio_capture.sv
// Scoreboard bench for sw_pio_capture with DEBOUNCE_CYCLES=4.
// Stimulus queues cycle-tagged expected words; a monitor compares on negedges.
module tb_sw_pio_capture;

    localparam int DC = 4;

    typedef struct {
        int          cyc;
        logic [31:0] exp;
        string       nm;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ack_bit;
    logic [13:0] mask;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          t_end;
    exp_t        sb[$];

    sw_pio_capture_if bus();

    sw_pio_capture #(
        .DEBOUNCE_CYCLES(DC),
        .EVT_CNT_W      (8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic expect_at(input int c, input logic [31:0] v, input string nm);
        exp_t e;
        e.cyc = c;
        e.exp = v;
        e.nm  = nm;
        sb.push_back(e);
    endtask

    task automatic drive_pp();
        bus.pp_out_axi = {4'b0, mask, 13'b0, ack_bit};
    endtask

    task automatic toggle_ack();
        ack_bit = ~ack_bit;
        drive_pp();
    endtask

    task automatic chk(input logic [31:0] v, input string nm);
        checks++;
        if (bus.pp_in_axi !== v) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %08h expected %08h",
                     nm, cyc, bus.pp_in_axi, v);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                checks++;
                if (bus.pp_in_axi !== e.exp) begin
                    errors++;
                    $display("FAIL %s @cyc %0d: got %08h expected %08h",
                             e.nm, cyc, bus.pp_in_axi, e.exp);
                end
            end
        end
    end

    initial begin
        bus.sw  = 10'h3FF;
        bus.key = 4'hF;
        ack_bit = 1'b0;
        mask    = 14'h3FFF;
        drive_pp();

        expect_at(1, 32'h0, "rst1");
        expect_at(2, 32'h0, "rst2");
        expect_at(3, 32'h0, "rst3");
        expect_at(9, 32'h0, "sw_pre");
        expect_at(10, 32'h0001_43FF, "sw_lat");
        wait_to(3);
        reset = 1'b0;

        wait_to(10);
        chk(32'h0001_43FF, "i_sw_lat");
        toggle_ack();
        expect_at(12, 32'h0001_03FF, "ack1");

        wait_to(12);
        chk(32'h0001_03FF, "i_ack1");
        bus.sw[3] = 1'b0;
        for (int c = 14; c <= 24; c++) expect_at(c, 32'h0001_03FF, "glitch");
        wait_to(15);
        bus.sw[3] = 1'b1;

        wait_to(24);
        bus.key[2] = 1'b0;
        expect_at(30, 32'h0001_03FF, "key_pre");
        expect_at(31, 32'h0C02_53FF, "key_evt");

        wait_to(31);
        chk(32'h0C02_53FF, "i_key_evt");
        toggle_ack();
        expect_at(32, 32'h0C02_53FF, "ack_wait");
        expect_at(33, 32'h0C02_13FF, "ack2");

        wait_to(33);
        bus.key[2] = 1'b1;
        expect_at(40, 32'h0C03_43FF, "evt3");

        wait_to(40);
        bus.sw[9] = 1'b0;
        expect_at(47, 32'h0904_C1FF, "ovf");

        wait_to(47);
        chk(32'h0904_C1FF, "i_ovf");
        toggle_ack();
        expect_at(49, 32'h0904_01FF, "ovf_clr");

        wait_to(49);
        bus.sw[1] = 1'b0;
        expect_at(56, 32'h0105_41FD, "evt5");

        wait_to(56);
        bus.sw[0] = 1'b0;
        expect_at(62, 32'h0105_41FD, "same_pre");
        expect_at(63, 32'h0006_41FC, "ack_evt");
        wait_to(61);
        toggle_ack();

        wait_to(63);
        chk(32'h0006_41FC, "i_ack_evt");
        toggle_ack();
        expect_at(65, 32'h0006_01FC, "clr6");

        for (int k = 0; k < 250; k++) begin
            wait_to(65 + 8 * k);
            bus.sw[8] = ~bus.sw[8];
            if (k == 0) expect_at(72, 32'h0807_40FC, "wrap_first");
            if (k == 249) begin
                expect_at(2063, 32'h08FF_C0FC, "cnt255");
                expect_at(2064, 32'h0800_C1FC, "wrap0");
            end
        end
        t_end = 2064;

`ifdef SW_PIO_CAPTURE_MASK_EN
        wait_to(2064);
        mask[5] = 1'b0;
        drive_pp();
        bus.sw[5] = 1'b0;
        expect_at(2072, 32'h0800_C1DC, "masked");
        t_end = 2072;
`endif

        wait_to(t_end);
        reset = 1'b1;
        expect_at(t_end + 1, 32'h0, "rst_mid1");
        expect_at(t_end + 2, 32'h0, "rst_mid2");
        expect_at(t_end + 3, 32'h0, "rst_mid3");
        wait_to(t_end + 2);
        reset = 1'b0;
        wait_to(t_end + 4);

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL %s: never compared, expected %08h at cyc %0d",
                     e.nm, e.exp, e.cyc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
